// File: rtl/uart_duty_pkg.sv
// Shared types, constants and helpers for the UART duty-word receive path.
package uart_duty_pkg;

   // Command parser states.
   typedef enum logic [1:0] {
      P_SYNC,
      P_CHAN,
      P_DATA,
      P_CSUM
   } parser_state_t;

   // Serial byte receiver states.
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'h53;
   localparam logic [7:0] CH_MAX    = 8'd1;

   // Clocks per bit, rounded to the nearest integer.
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_duty_rx_if.sv
// Serial input and duty-register outputs of the duty receiver, bundled.
// master: the receiver (reads the line, drives the duty words).
// slave:  the consumer (drives the line, reads the duty words).
interface uart_duty_rx_if #(
   parameter int DUTY_W = 24
);
   logic              uart_rx;
   logic [DUTY_W-1:0] duty0;
   logic [DUTY_W-1:0] duty1;
   logic              upd;
   logic              upd_ch;
   logic [7:0]        err_cnt;

   modport master (
      input  uart_rx,
      output duty0,
      output duty1,
      output upd,
      output upd_ch,
      output err_cnt
   );

   modport slave (
      output uart_rx,
      input  duty0,
      input  duty1,
      input  upd,
      input  upd_ch,
      input  err_cnt
   );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, baud counter and bit FSM.
// Emits a one-cycle byte_valid (stop bit high) or frame_err (stop bit low)
// at the centre of the stop bit.
module uart_rx_byte
   import uart_duty_pkg::*;
#(
   parameter int DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int               HALF      = DIV / 2;
   localparam int               CNT_W     = $clog2(DIV);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);

   logic             rx_meta;
   logic             rx_sync;
   rx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking so rx_sync takes the old rx_meta, giving two real stages.
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
      end
   end

   // Bit FSM: centre-samples start, 8 data bits LSB-first, then the stop bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (!rx_sync) begin
                  state <= RX_START;
                  cnt   <= '0;
               end
            end
            RX_START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  // A line already back high at mid-start is a glitch.
                  if (rx_sync) begin
                     state <= RX_IDLE;
                  end else begin
                     state   <= RX_DATA;
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shift <= {rx_sync, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= RX_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  // Re-arm in the stop sample cycle so back-to-back bytes work.
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shift;
                     state      <= RX_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= RX_WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_WAIT_HIGH: begin
               if (rx_sync) begin
                  state <= RX_IDLE;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_duty_rx.sv
// UART command receiver that sets the two PWM duty words.
// Frame: 0x53, channel (0/1), NB data bytes MSB-first, XOR checksum of
// channel and data bytes. Rejected frames/bytes bump a saturating counter.
module uart_duty_rx
   import uart_duty_pkg::*;
#(
   parameter int                CLK_HZ      = 96_000_000,
   parameter int                BAUD        = 115200,
   parameter int                DUTY_W      = 24,
   parameter logic [DUTY_W-1:0] DUTY0_RST   = '0,
   parameter logic [DUTY_W-1:0] DUTY1_RST   = '0,
   parameter int                TIMEOUT_CYC = 20 * calc_div(CLK_HZ, BAUD)
) (
   input logic            clk,
   input logic            rst,
   uart_duty_rx_if.master bus
);

   localparam int               DIV     = calc_div(CLK_HZ, BAUD);
   localparam int               NB      = DUTY_W / 8;
   localparam int               BC_W    = $clog2(NB + 1);
   localparam logic [BC_W-1:0]  NB_LAST = BC_W'(NB - 1);
   localparam int               GAP_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYC);

   if (DIV < 4) begin : g_bad_div
      $error("uart_duty_rx: clocks per bit must be at least 4");
   end
   if ((DUTY_W % 8) != 0 || DUTY_W < 8) begin : g_bad_width
      $error("uart_duty_rx: DUTY_W must be a non-zero multiple of 8");
   end

   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              frame_err;

   parser_state_t     pstate;
   logic              ch;
   logic [DUTY_W-1:0] shadow;
   logic [7:0]        csum;
   logic [BC_W-1:0]   byte_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [DUTY_W-1:0] duty0_q;
   logic [DUTY_W-1:0] duty1_q;
   logic              upd_q;
   logic              upd_ch_q;
   logic [7:0]        err_q;

   logic              timeout;
   logic              err_evt;

   uart_rx_byte #(
      .DIV (DIV)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (bus.uart_rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   // Classify the current cycle: any error returns the parser to P_SYNC.
   always_comb begin
      // NOTE: every output gets a default before the case, so no latch is inferred.
      timeout = (pstate != P_SYNC) && (gap_cnt == GAP_MAX) && !byte_valid;
      err_evt = frame_err | timeout;
      if (byte_valid) begin
         case (pstate)
            P_CHAN:  if (byte_data > CH_MAX) err_evt = 1'b1;
            P_CSUM:  if (byte_data != csum)  err_evt = 1'b1;
            default: ;
         endcase
      end
   end

   // Parser FSM, inter-byte gap counter, duty registers and error counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pstate   <= P_SYNC;
         ch       <= 1'b0;
         shadow   <= '0;
         csum     <= '0;
         byte_cnt <= '0;
         gap_cnt  <= '0;
         duty0_q  <= DUTY0_RST;
         duty1_q  <= DUTY1_RST;
         upd_q    <= 1'b0;
         upd_ch_q <= 1'b0;
         err_q    <= '0;
      end else begin
         upd_q <= 1'b0;

         // Gap only matters inside a frame; it restarts on every good byte.
         if (byte_valid || pstate == P_SYNC) begin
            gap_cnt <= '0;
         end else if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + 1'b1;
         end

         if (err_evt) begin
            pstate <= P_SYNC;
            if (err_q != 8'hFF) begin
               err_q <= err_q + 8'd1;
            end
         end else if (byte_valid) begin
            case (pstate)
               P_SYNC: begin
                  if (byte_data == SYNC_BYTE) begin
                     pstate <= P_CHAN;
                  end
               end
               P_CHAN: begin
                  ch       <= byte_data[0];
                  csum     <= byte_data;
                  byte_cnt <= '0;
                  pstate   <= P_DATA;
               end
               P_DATA: begin
                  shadow <= DUTY_W'({shadow, byte_data});
                  csum   <= csum ^ byte_data;
                  if (byte_cnt == NB_LAST) begin
                     pstate <= P_CSUM;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
               P_CSUM: begin
                  // Checksum matched (mismatch was taken as an error above).
                  if (ch) begin
                     duty1_q <= shadow;
                  end else begin
                     duty0_q <= shadow;
                  end
                  upd_q    <= 1'b1;
                  upd_ch_q <= ch;
                  pstate   <= P_SYNC;
               end
               default: pstate <= P_SYNC;
            endcase
         end
      end
   end

   assign bus.duty0   = duty0_q;
   assign bus.duty1   = duty1_q;
   assign bus.upd     = upd_q;
   assign bus.upd_ch  = upd_ch_q;
   assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_uart_duty_rx.sv
// Directed bench for uart_duty_rx at CLK_HZ=16, BAUD=1 (16 clocks per bit).
module tb_uart_duty_rx;

   localparam int DIV = 16;

   logic clk = 1'b0;
   logic rst;

   uart_duty_rx_if #(.DUTY_W(24)) bus ();

   uart_duty_rx #(
      .CLK_HZ      (16),
      .BAUD        (1),
      .DUTY_W      (24),
      .DUTY0_RST   (24'h0),
      .DUTY1_RST   (24'h0),
      .TIMEOUT_CYC (320)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Count upd-high cycles and remember the last pulse.
   int unsigned upd_cnt      = 0;
   int unsigned last_upd_cyc = 0;
   logic        last_upd_ch  = 1'b0;
   always @(negedge clk) begin
      if (bus.upd === 1'b1) begin
         upd_cnt++;
         last_upd_cyc = cyc;
         last_upd_ch  = bus.upd_ch;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int unsigned csum_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 with the line high.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      bus.uart_rx = 1'b0;
      repeat (DIV) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         bus.uart_rx = b[i];
         repeat (DIV) @(posedge clk);
         #1;
      end
      bus.uart_rx = stop_bit;
      repeat (DIV) @(posedge clk);
      #1;
      bus.uart_rx = 1'b1;
      if (!stop_bit) begin
         repeat (4) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] ch, input logic [23:0] d, input logic [7:0] cs);
      send_byte(8'h53, 1'b1);
      send_byte(ch, 1'b1);
      send_byte(d[23:16], 1'b1);
      send_byte(d[15:8], 1'b1);
      send_byte(d[7:0], 1'b1);
      csum_cyc = cyc;
      send_byte(cs, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      bus.uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_duty0", 32'(bus.duty0), 32'h0);
      check("rst_duty1", 32'(bus.duty1), 32'h0);
      check("rst_upd", 32'(bus.upd), 32'h0);
      check("rst_upd_ch", 32'(bus.upd_ch), 32'h0);
      check("rst_err", 32'(bus.err_cnt), 32'h0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Good frame to channel 1: upd one cycle after stop-bit centre (byte start + 156).
      send_frame(8'h01, 24'h123456, 8'h71);
      check("t1_duty1", 32'(bus.duty1), 32'h123456);
      check("t1_duty0", 32'(bus.duty0), 32'h0);
      check("t1_upd_cnt", upd_cnt, 32'd1);
      check("t1_upd_ch", 32'(last_upd_ch), 32'h1);
      check("t1_upd_cyc", last_upd_cyc, csum_cyc + 32'd156);
      check("t1_err", 32'(bus.err_cnt), 32'd0);

      // Bad checksum, then the same frame with the right checksum.
      send_frame(8'h01, 24'h123456, 8'h70);
      check("t2_err", 32'(bus.err_cnt), 32'd1);
      check("t2_no_upd", upd_cnt, 32'd1);
      check("t2_duty1", 32'(bus.duty1), 32'h123456);
      check("t2_duty0", 32'(bus.duty0), 32'h0);
      send_frame(8'h01, 24'h123456, 8'h71);
      check("t2_resend_upd", upd_cnt, 32'd2);
      check("t2_resend_err", 32'(bus.err_cnt), 32'd1);

      // Bad channel byte; trailing bytes are dropped silently in P_SYNC.
      send_byte(8'h53, 1'b1);
      send_byte(8'h02, 1'b1);
      check("t3_err_chan", 32'(bus.err_cnt), 32'd2);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h71, 1'b1);
      check("t3_err_after", 32'(bus.err_cnt), 32'd2);
      check("t3_upd", upd_cnt, 32'd2);

      // 5-cycle low glitch: ignored.
      bus.uart_rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.uart_rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("t4_glitch_err", 32'(bus.err_cnt), 32'd2);
      check("t4_glitch_upd", upd_cnt, 32'd2);
      // Stop bit low: framing error, then recovery.
      send_byte(8'h55, 1'b0);
      check("t4_stop_err", 32'(bus.err_cnt), 32'd3);
      send_frame(8'h00, 24'hAABBCC, 8'hDD);
      check("t4_rec_duty0", 32'(bus.duty0), 32'hAABBCC);
      check("t4_rec_duty1", 32'(bus.duty1), 32'h123456);
      check("t4_rec_ch", 32'(last_upd_ch), 32'h0);
      check("t4_rec_err", 32'(bus.err_cnt), 32'd3);

      // Partial frame, then idle: timeout only after 320 gap cycles.
      send_byte(8'h53, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hAB, 1'b1);
      repeat (300) @(posedge clk);
      #1;
      check("t5_before_to", 32'(bus.err_cnt), 32'd3);
      repeat (100) @(posedge clk);
      #1;
      check("t5_timeout", 32'(bus.err_cnt), 32'd4);
      send_frame(8'h00, 24'h000001, 8'h01);
      check("t5_duty0", 32'(bus.duty0), 32'h000001);
      check("t5_err", 32'(bus.err_cnt), 32'd4);
      check("t5_upd", upd_cnt, 32'd4);

      // 300 framing errors: counter saturates at 255.
      for (int k = 0; k < 300; k++) begin
         send_byte(8'h00, 1'b0);
      end
      check("t6_sat", 32'(bus.err_cnt), 32'd255);
      check("t6_no_upd", upd_cnt, 32'd4);
      send_frame(8'h01, 24'hABCDEF, 8'h88);
      check("t6_duty1", 32'(bus.duty1), 32'hABCDEF);
      check("t6_upd_ch", 32'(bus.upd_ch), 32'h1);
      check("t6_sat_hold", 32'(bus.err_cnt), 32'd255);

      // Reset in the middle of a byte inside a frame.
      send_byte(8'h53, 1'b1);
      send_byte(8'h01, 1'b1);
      bus.uart_rx = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      rst         = 1'b1;
      bus.uart_rx = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_duty0", 32'(bus.duty0), 32'h0);
      check("mid_rst_duty1", 32'(bus.duty1), 32'h0);
      check("mid_rst_upd", 32'(bus.upd), 32'h0);
      check("mid_rst_upd_ch", 32'(bus.upd_ch), 32'h0);
      check("mid_rst_err", 32'(bus.err_cnt), 32'h0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send_frame(8'h00, 24'h123456, 8'h70);
      check("post_rst_duty0", 32'(bus.duty0), 32'h123456);
      check("post_rst_duty1", 32'(bus.duty1), 32'h0);
      check("post_rst_err", 32'(bus.err_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
